vptl_gate_ic_tester: RTL and testbench

Sequential tester that exercises a physical or modelled 14-pin 74xx quad/hex gate IC (7404 NOT, 7408 AND, 7400 NAND, 7432 OR, 7486 XOR) through a 14-pin socket interface. It drives the chip's input pins, waits for settling, samples the chip's output pins and compares each gate against its expected truth table. It reports per-gate fail flags and an overall pass bit. It sits on the driving/checking side of the socket, opposite the gate-IC models.

---
 rtl/vptl_gate_ic_tester.sv | 103 ++++++++++
 tb/tb_vptl_gate_ic_tester.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vptl_gate_ic_tester.sv
// vptl_gate_ic_tester: drives a 14-pin 74xx gate IC through its truth table and flags failing gates
module vptl_gate_ic_tester #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [2:0]  i_chip_sel,
  output logic [13:0] o_pin_drv,
  output logic [13:0] o_pin_oe,
  input  logic [13:0] i_pin_sense,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic [5:0]  o_gate_fail,
  output logic        o_err_sel
);
  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_SAMPLE, S_DONE} state_t;
  state_t      r_state, w_next;
  logic [2:0]  r_sel, w_sel;
  logic [1:0]  r_vec, w_vec;
  logic [7:0]  r_cnt;
  logic [13:0] r_s1, r_s2, r_drv, r_oe, w_drv, w_oe;
  logic [5:0]  r_fail, w_mis;
  logic        r_pass, r_err, w_not, w_valid, w_last, w_a, w_b, w_ra, w_rb, w_y;
  logic        w_unused_sense;
  // Drive values look ahead to the vector being entered; compare uses the vector held now.
  always_comb begin
    w_sel = (r_state == S_IDLE) ? i_chip_sel : r_sel;
    w_valid = i_chip_sel <= 3'd4;
    w_vec = (r_state == S_SAMPLE) ? r_vec + 2'd1 : 2'd0;
    w_not = w_sel == 3'd0;
    w_a = w_not ? w_vec[0] : w_vec[1];
    w_b = w_vec[0];
    w_ra = w_not ? r_vec[0] : r_vec[1];
    w_rb = r_vec[0];
    w_drv = w_not ? (({14{w_a}} & 14'h1515) | 14'h2000)
                  : (({14{w_a}} & 14'h0909) | ({14{w_b}} & 14'h1212) | 14'h2000);
    w_oe = w_not ? 14'h3555 : 14'h3B5B;
    w_y = (r_sel == 3'd1) ? (w_ra & w_rb) :
          (r_sel == 3'd2) ? ~(w_ra & w_rb) :
          (r_sel == 3'd3) ? (w_ra | w_rb) : (w_ra ^ w_rb);
    w_mis = w_not ? ({r_s2[11], r_s2[9], r_s2[7], r_s2[5], r_s2[3], r_s2[1]} ^ {6{~w_ra}})
                  : {2'b00, {r_s2[10], r_s2[7], r_s2[5], r_s2[2]} ^ {4{w_y}}};
    w_last = r_vec == (w_not ? 2'd1 : 2'd3);
    w_unused_sense = ^{r_s2[13:12], r_s2[8], r_s2[6], r_s2[4], r_s2[0]};
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = i_start ? (w_valid ? S_APPLY : S_DONE) : S_IDLE;
      S_APPLY:  w_next = S_SETTLE;
      S_SETTLE: w_next = (r_cnt == 8'd0) ? S_SAMPLE : S_SETTLE;
      S_SAMPLE: w_next = w_last ? S_DONE : S_APPLY;
      default:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_sel <= '0;
      r_vec <= '0;
      r_cnt <= '0;
      r_s1 <= '0;
      r_s2 <= '0;
      r_drv <= '0;
      r_oe <= '0;
      r_fail <= '0;
      r_pass <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_s1 <= i_pin_sense;
      r_s2 <= r_s1;
      if (w_next == S_APPLY) begin
        r_vec <= w_vec;
        r_drv <= w_drv;
        r_oe <= w_oe;
      end
      if (w_next == S_DONE) begin
        r_drv <= '0;
        r_oe <= '0;
      end
      if (r_state == S_IDLE && i_start) begin
        r_sel <= i_chip_sel;
        r_fail <= '0;
        r_pass <= 1'b0;
        r_err <= ~w_valid;
      end
      if (r_state == S_APPLY) r_cnt <= 8'(SETTLE_CYCLES - 1);
      else if (r_state == S_SETTLE) r_cnt <= r_cnt - 8'd1;
      if (r_state == S_SAMPLE) begin
        r_fail <= r_fail | w_mis;
        if (w_last) r_pass <= ~|(r_fail | w_mis);
      end
    end
  end
  assign o_pin_drv = r_drv;
  assign o_pin_oe = r_oe;
  assign o_busy = r_state != S_IDLE;
  assign o_done = r_state == S_DONE;
  assign o_pass = r_pass;
  assign o_gate_fail = r_fail;
  assign o_err_sel = r_err;
endmodule

// File: tb/tb_vptl_gate_ic_tester.sv
// tb_vptl_gate_ic_tester: pin-level gate-IC models looped back into the tester, checked against a vector table
module tb_vptl_gate_ic_tester;
  logic        i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0;
  logic [2:0]  i_chip_sel = '0;
  logic [13:0] o_pin_drv, o_pin_oe, sense, stuck0 = '0;
  logic        o_busy, o_done, o_pass, o_err_sel;
  logic [5:0]  o_gate_fail;
  int          model = 1, checks = 0, errors = 0;

  vptl_gate_ic_tester dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_chip_sel(i_chip_sel),
    .o_pin_drv(o_pin_drv), .o_pin_oe(o_pin_oe), .i_pin_sense(sense),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
    .o_gate_fail(o_gate_fail), .o_err_sel(o_err_sel)
  );

  always #5 i_clk = ~i_clk;

  // model: 0 NOT, 1 AND, 2 NAND, 3 OR, 4 XOR, 5 XNOR
  function automatic logic gf(input int m, input logic a, input logic b);
    case (m)
      1: return a & b;
      2: return ~(a & b);
      3: return a | b;
      4: return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  always_comb begin
    sense = o_pin_drv;
    if (model == 0) begin
      sense[1] = ~o_pin_drv[0];
      sense[3] = ~o_pin_drv[2];
      sense[5] = ~o_pin_drv[4];
      sense[7] = ~o_pin_drv[8];
      sense[9] = ~o_pin_drv[10];
      sense[11] = ~o_pin_drv[12];
    end else begin
      sense[2] = gf(model, o_pin_drv[0], o_pin_drv[1]);
      sense[5] = gf(model, o_pin_drv[3], o_pin_drv[4]);
      sense[7] = gf(model, o_pin_drv[8], o_pin_drv[9]);
      sense[10] = gf(model, o_pin_drv[11], o_pin_drv[12]);
    end
    sense = sense & ~stuck0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Counts edges after the accepting edge until o_done is seen.
  task automatic run(input logic [2:0] sel, output int n, output logic [13:0] oe_seen);
    i_chip_sel = sel;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    n = 0;
    oe_seen = o_pin_oe;
    while (!o_done && n < 200) begin
      @(posedge i_clk); #1;
      n++;
      oe_seen |= o_pin_oe;
    end
  endtask

  typedef struct {
    logic [2:0]  sel;
    int          model;
    logic [13:0] stuck;
    logic [5:0]  fail;
    logic        pass;
    logic        err;
    int          cyc;
  } vec_t;

  vec_t tv[11];
  int n, dones;
  logic [13:0] oe_seen;

  initial begin
    tv[0]  = '{3'd1, 1, 14'h0000, 6'b000000, 1'b1, 1'b0, 24};
    tv[1]  = '{3'd2, 2, 14'h0000, 6'b000000, 1'b1, 1'b0, 24};
    tv[2]  = '{3'd3, 3, 14'h0000, 6'b000000, 1'b1, 1'b0, 24};
    tv[3]  = '{3'd4, 4, 14'h0000, 6'b000000, 1'b1, 1'b0, 24};
    tv[4]  = '{3'd0, 0, 14'h0000, 6'b000000, 1'b1, 1'b0, 12};
    tv[5]  = '{3'd6, 1, 14'h0000, 6'b000000, 1'b0, 1'b1, 0};
    tv[6]  = '{3'd4, 5, 14'h0000, 6'b001111, 1'b0, 1'b0, 24};
    tv[7]  = '{3'd0, 0, 14'h0200, 6'b010000, 1'b0, 1'b0, 12};
    tv[8]  = '{3'd7, 1, 14'h0000, 6'b000000, 1'b0, 1'b1, 0};
    tv[9]  = '{3'd1, 3, 14'h0000, 6'b001111, 1'b0, 1'b0, 24};
    tv[10] = '{3'd3, 3, 14'h0080, 6'b000100, 1'b0, 1'b0, 24};

    #12;
    chk("reset oe", 32'(o_pin_oe), 0);
    chk("reset drv", 32'(o_pin_drv), 0);
    chk("reset busy/done/pass/err", {o_busy, o_done, o_pass, o_err_sel}, 0);
    chk("reset gate_fail", 32'(o_gate_fail), 0);
    #10 i_rst = 1'b0;
    @(posedge i_clk); #1;

    for (int i = 0; i < 11; i++) begin
      model = tv[i].model;
      stuck0 = tv[i].stuck;
      run(tv[i].sel, n, oe_seen);
      chk($sformatf("vec%0d done_edge", i), n, tv[i].cyc);
      chk($sformatf("vec%0d pass", i), 32'(o_pass), 32'(tv[i].pass));
      chk($sformatf("vec%0d gate_fail", i), 32'(o_gate_fail), 32'(tv[i].fail));
      chk($sformatf("vec%0d err_sel", i), 32'(o_err_sel), 32'(tv[i].err));
      chk($sformatf("vec%0d busy_in_done", i), 32'(o_busy), 1);
      chk($sformatf("vec%0d oe_in_done", i), 32'(o_pin_oe), 0);
      if (tv[i].err) chk($sformatf("vec%0d oe_seen", i), 32'(oe_seen), 0);
      @(posedge i_clk); #1;
      chk($sformatf("vec%0d done_pulse", i), 32'(o_done), 0);
      chk($sformatf("vec%0d pass_held", i), 32'(o_pass), 32'(tv[i].pass));
      chk($sformatf("vec%0d fail_held", i), 32'(o_gate_fail), 32'(tv[i].fail));
    end
    stuck0 = '0;

    // Good 7408: drive check on vector 11, select changed mid-test, start held across DONE
    model = 1;
    i_chip_sel = 3'd1;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_chip_sel = 3'd6;
    repeat (18) begin @(posedge i_clk); #1; end
    chk("and v11 drv pins 1,2,7,14", {o_pin_drv[0], o_pin_drv[1], o_pin_drv[6], o_pin_drv[13]}, 4'b1101);
    chk("and v11 oe", 32'(o_pin_oe), 32'h3B5B);
    n = 18;
    while (!o_done && n < 200) begin @(posedge i_clk); #1; n++; end
    chk("and done_edge", n, 24);
    chk("and pass", 32'(o_pass), 1);
    chk("and err_sel", 32'(o_err_sel), 0);
    i_chip_sel = 3'd1;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    chk("start in done ignored", 32'(o_busy), 0);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    chk("held start restarts", 32'(o_busy), 1);
    chk("restart clears pass", 32'(o_pass), 0);
    n = 0;
    while (!o_done && n < 200) begin @(posedge i_clk); #1; n++; end
    chk("restart done_edge", n, 24);
    chk("restart pass", 32'(o_pass), 1);
    @(posedge i_clk); #1;

    // Invalid select with a second start pulse in DONE
    i_chip_sel = 3'd6;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    chk("inv done at E0+1", 32'(o_done), 1);
    chk("inv oe", 32'(o_pin_oe), 0);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    chk("inv second start ignored", {o_busy, o_done}, 0);
    chk("inv err held", 32'(o_err_sel), 1);
    @(posedge i_clk); #1;
    chk("inv stays idle", 32'(o_busy), 0);

    // Reset during SETTLE of vector 2 on a 7432
    model = 3;
    i_chip_sel = 3'd3;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (14) begin @(posedge i_clk); #1; end
    chk("rst pre oe", 32'(o_pin_oe), 32'h3B5B);
    #2 i_rst = 1'b1;
    #1;
    chk("rst async oe", 32'(o_pin_oe), 0);
    chk("rst async drv", 32'(o_pin_drv), 0);
    chk("rst busy/done", {o_busy, o_done}, 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    dones = 0;
    repeat (30) begin @(posedge i_clk); #1; if (o_done) dones++; end
    chk("rst no done", dones, 0);
    run(3'd3, n, oe_seen);
    chk("post-rst done_edge", n, 24);
    chk("post-rst pass", 32'(o_pass), 1);
    @(posedge i_clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
